// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sort_pkg
// Purpose : Shared types and constants for the sort controller and the
//           bubble-sort engine it sequences.
// Contents: state_t    - controller state encoding
//           CAPACITY   - default packet capacity (2**AWIDTH_DEF words)
//           capacity() - capacity in words for a given address width
// Revision: 1.0 - initial release
// ============================================================================
package sort_pkg;

   localparam int AWIDTH_DEF = 4;
   localparam int CAPACITY   = 1 << AWIDTH_DEF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_START = 3'd2,
      ST_SORT  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   function automatic int capacity(input int aw);
      return 1 << aw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sort_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sort_ctrl_if
// Purpose : Bundles the packet input, engine and packet output signals of
//           the sort controller.
// Ports   : master - controller side (drives ready/write/start/read/output)
//           slave  - environment side (packet source, engine, consumer)
// Revision: 1.0 - initial release
// ============================================================================
interface sort_ctrl_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
) ();

   // packet input
   logic [DWIDTH-1:0] data_i;
   logic              sop_i;
   logic              eop_i;
   logic              val_i;
   logic              ready_o;
   // engine write port
   logic              wr_en_o;
   logic [AWIDTH-1:0] wr_addr_o;
   logic [DWIDTH-1:0] wr_data_o;
   // engine control
   logic              do_work_o;
   logic [AWIDTH-1:0] wrpntr_o;
   logic              done_i;
   // engine read port
   logic              rd_req_o;
   logic [AWIDTH-1:0] rd_addr_o;
   logic [DWIDTH-1:0] rd_data_i;
   // packet output
   logic [DWIDTH-1:0] data_o;
   logic              val_o;
   logic              sop_o;
   logic              eop_o;
   logic              err_o;

   modport master (
      input  data_i, sop_i, eop_i, val_i, done_i, rd_data_i,
      output ready_o, wr_en_o, wr_addr_o, wr_data_o, do_work_o, wrpntr_o,
             rd_req_o, rd_addr_o, data_o, val_o, sop_o, eop_o, err_o
   );

   modport slave (
      output data_i, sop_i, eop_i, val_i, done_i, rd_data_i,
      input  ready_o, wr_en_o, wr_addr_o, wr_data_o, do_work_o, wrpntr_o,
             rd_req_o, rd_addr_o, data_o, val_o, sop_o, eop_o, err_o
   );

endinterface
`default_nettype wire

// File: rtl/sort_wdog.sv
`default_nettype none
// ============================================================================
// Module  : sort_wdog
// Purpose : Sort-phase watchdog. The counter holds the number of cycles
//           elapsed since the start strobe; expiry flags when it reaches
//           all-ones while the sort is still running.
// Ports   : clk_i, srst_i - clock, synchronous active-high reset
//           clear_i       - start strobe (restarts the count)
//           run_i         - controller is waiting for the engine
//           expire_o      - timeout reached this cycle
// Revision: 1.0 - initial release
// ============================================================================
module sort_wdog #(
   parameter int WDOG_W = 12
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic clear_i,
   input  logic run_i,
   output logic expire_o
);

   logic [WDOG_W-1:0] count;

   assign expire_o = run_i && (count == '1);

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         count <= '0;
      end else if (clear_i) begin
         // the first wait cycle already counts as one elapsed cycle
         count <= WDOG_W'(1);
      end else if (run_i && !expire_o) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sort_ctrl
// Purpose : Packet-level sequencer for the bubble-sort engine: collects one
//           packet into engine memory, strobes the sort, waits for done and
//           reads the sorted words back out as a framed packet.
// Ports   : clk_i  - clock
//           srst_i - synchronous active-high reset
//           bus    - sort_ctrl_if.master (input packet, engine write/read,
//                    start/done, output packet, err_o)
// Config  : SORT_CTRL_WDOG_EN - enables the sort-phase watchdog (sort_wdog);
//           without it err_o is tied low and SORT waits indefinitely.
// Revision: 1.0 - initial release
// ============================================================================
module sort_ctrl
   import sort_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4,
   parameter int WDOG_W = 12
) (
   input  logic        clk_i,
   input  logic        srst_i,
   sort_ctrl_if.master bus
);

   localparam logic [AWIDTH:0] CNT_FULL = (AWIDTH+1)'(capacity(AWIDTH));
   localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);

   state_t            state, state_nxt;
   logic [AWIDTH:0]   cnt, cnt_nxt, cnt_m1;
   logic [AWIDTH-1:0] last_idx, rd_idx;
   logic              ready, accept, do_work, rd_req;
   logic              rd_all;                     // every address issued
   logic              rd_vld, rd_first, rd_last;  // aligned with rd_data_i
   logic              wdog_expire;

   assign cnt_m1   = cnt - 1'b1;
   assign last_idx = cnt_m1[AWIDTH-1:0];

   // Combinational outputs are forced low during reset so nothing leaks
   // out of a packet that is being discarded.
   assign ready   = ((state == ST_IDLE) || (state == ST_FILL)) && !srst_i;
   assign accept  = bus.val_i && ready;
   assign do_work = (state == ST_START) && (cnt > CNT_ONE) && !srst_i;
   assign rd_req  = (state == ST_DRAIN) && !rd_all && !srst_i;

   assign bus.ready_o   = ready;
   assign bus.do_work_o = do_work;
   assign bus.rd_req_o  = rd_req;
   assign bus.rd_addr_o = rd_idx;
   assign bus.wrpntr_o  = ((state == ST_START) || (state == ST_SORT) ||
                           (state == ST_DRAIN)) && !srst_i ? last_idx : '0;

`ifdef SORT_CTRL_WDOG_EN
   sort_wdog #(
      .WDOG_W (WDOG_W)
   ) u_wdog (
      .clk_i    (clk_i),
      .srst_i   (srst_i),
      .clear_i  (do_work),
      .run_i    (state == ST_SORT),
      .expire_o (wdog_expire)
   );
`else
   assign wdog_expire = 1'b0;
`endif

   // done_i arriving in the expiry cycle still wins
   assign bus.err_o = (state == ST_SORT) && wdog_expire && !bus.done_i && !srst_i;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bus.wr_en_o   = 1'b0;
      bus.wr_addr_o = '0;
      bus.wr_data_o = '0;
      case (state)
         ST_IDLE: begin
            // words outside a packet are dropped until a sop arrives
            if (accept && bus.sop_i) begin
               bus.wr_en_o   = 1'b1;
               bus.wr_data_o = bus.data_i;
               cnt_nxt       = CNT_ONE;
               state_nxt     = bus.eop_i ? ST_START : ST_FILL;
            end
         end
         ST_FILL: begin
            if (accept) begin
               if (bus.sop_i) begin
                  bus.wr_en_o   = 1'b1;
                  bus.wr_data_o = bus.data_i;
                  cnt_nxt       = CNT_ONE;
               end else if (cnt != CNT_FULL) begin
                  bus.wr_en_o   = 1'b1;
                  bus.wr_addr_o = cnt[AWIDTH-1:0];
                  bus.wr_data_o = bus.data_i;
                  cnt_nxt       = cnt + 1'b1;
               end
               if (bus.eop_i) begin
                  state_nxt = ST_START;
               end
            end
         end
         ST_START: begin
            // a single word is already sorted: skip the engine
            state_nxt = (cnt > CNT_ONE) ? ST_SORT : ST_DRAIN;
         end
         ST_SORT: begin
            if (bus.done_i) begin
               state_nxt = ST_DRAIN;
            end else if (wdog_expire) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // stay until the last word has left the output register
            if (bus.eop_o) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Read sequencing and output pipeline: request -> engine data -> output.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rd_idx     <= '0;
         rd_all     <= 1'b0;
         rd_vld     <= 1'b0;
         rd_first   <= 1'b0;
         rd_last    <= 1'b0;
         bus.data_o <= '0;
         bus.val_o  <= 1'b0;
         bus.sop_o  <= 1'b0;
         bus.eop_o  <= 1'b0;
      end else begin
         if (state != ST_DRAIN) begin
            rd_idx <= '0;
            rd_all <= 1'b0;
         end else if (rd_req) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == last_idx) begin
               rd_all <= 1'b1;
            end
         end
         rd_vld     <= rd_req;
         rd_first   <= rd_req && (rd_idx == '0);
         rd_last    <= rd_req && (rd_idx == last_idx);
         bus.val_o  <= rd_vld;
         bus.sop_o  <= rd_first;
         bus.eop_o  <= rd_last;
         bus.data_o <= rd_vld ? bus.rd_data_i : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sort_ctrl
// Purpose : Self-checking bench for sort_ctrl with a simple engine model.
//           Build with SORT_CTRL_WDOG_EN to exercise the watchdog (WDOG_W=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sort_ctrl;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int CAP = 1 << AW;
`ifdef SORT_CTRL_WDOG_EN
   localparam int WW  = 4;
`else
   localparam int WW  = 12;
`endif

   typedef logic [DW-1:0] word_t;
   typedef word_t arr_t [CAP];
   typedef struct {
      word_t d;
      bit    s;
      bit    e;
   } exp_t;

   logic clk  = 1'b0;
   logic srst = 1'b1;
   int   cyc  = 0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sort_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   sort_ctrl #(
      .DWIDTH (DW),
      .AWIDTH (AW),
      .WDOG_W (WW)
   ) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .bus    (bus)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard state ----------------
   exp_t  exp_q[$];
   word_t cap_q[$];
   word_t m_words[$];
   bit    m_active = 0;
   int    cur_len = 0, eop_cyc = 0, done_cyc = 0, dw_cyc = 0;
   int    dw_cnt = 0, wp_seen = -1, err_cnt = 0, err_cyc = -1;
   bit    eng_hold = 0;
   int    eng_fix  = 0;
   bit    do_sort  = 0;
   int    sort_len = 0;

   // ---------------- engine model ----------------
   function automatic arr_t engine_sort(input arr_t a, input int n);
      arr_t  r;
      word_t t;
      r = a;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n - 1 - i; j++)
            if (r[j] > r[j+1]) begin
               t = r[j]; r[j] = r[j+1]; r[j+1] = t;
            end
      return r;
   endfunction

   arr_t mem;

   always @(posedge clk) begin
      if (do_sort) mem <= engine_sort(mem, sort_len);
      else if (bus.wr_en_o) mem[bus.wr_addr_o] <= bus.wr_data_o;
      if (bus.rd_req_o) bus.rd_data_i <= mem[bus.rd_addr_o];
   end

   initial begin
      bus.done_i = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.do_work_o) begin
            dw_cnt++;
            dw_cyc  = cyc;
            wp_seen = int'(bus.wrpntr_o);
            check("do_work_lat", cyc, eop_cyc + 1);
            check("wrpntr_start", int'(bus.wrpntr_o), cur_len - 1);
            check("do_work_len", int'(cur_len > 1), 1);
            sort_len = int'(bus.wrpntr_o) + 1;
            if (!eng_hold) begin
               repeat ((eng_fix > 0) ? eng_fix : int'($urandom_range(1, 8))) @(negedge clk);
               do_sort    = 1'b1;
               bus.done_i = 1'b1;
               done_cyc   = cyc;
               @(negedge clk);
               do_sort    = 1'b0;
               bus.done_i = 1'b0;
            end
         end
      end
   end

   // ---------------- output compare ----------------
   bit   in_burst = 0, ready_due = 0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (srst) begin
         in_burst  = 0;
         ready_due = 0;
      end else begin
         if (ready_due) begin
            check("ready_after_eop", int'(bus.ready_o), 1);
            ready_due = 0;
         end
         if (bus.val_o) begin
            cap_q.push_back(bus.data_o);
            if (exp_q.size() == 0) check("val_unexpected", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               check("data_o", int'(bus.data_o), int'(mon_e.d));
               check("sop_o", int'(bus.sop_o), int'(mon_e.s));
               check("eop_o", int'(bus.eop_o), int'(mon_e.e));
            end
            if (bus.sop_o) begin
               check("wrpntr_drain", int'(bus.wrpntr_o), cur_len - 1);
               if (cur_len > 1) check("first_val_lat", cyc, done_cyc + 3);
            end
            in_burst = !bus.eop_o;
            if (bus.eop_o) ready_due = 1;
         end else if (in_burst) begin
            check("val_gap", 0, 1);
            in_burst = 0;
         end
         if (bus.err_o) begin
            err_cnt++;
            err_cyc = cyc;
         end
      end
   end

   // ---------------- reference packet model + driver ----------------
   task automatic close_pkt();
      word_t srt[$];
      exp_t  e;
      srt = m_words;
      srt.sort();
      cur_len = srt.size();
      for (int i = 0; i < cur_len; i++) begin
         e.d = srt[i];
         e.s = (i == 0);
         e.e = (i == cur_len - 1);
         exp_q.push_back(e);
      end
      m_words.delete();
      m_active = 0;
   endtask

   task automatic beat(input word_t d, input bit s, input bit e);
      int n;
      bit we;
      n = 0;
      bus.val_i  = 1'b1;
      bus.data_i = d;
      bus.sop_i  = s;
      bus.eop_i  = e;
      #1;
      while (!bus.ready_o && n < 3000) begin
         @(negedge clk); #1; n++;
      end
      check("ready_timeout", int'(bus.ready_o), 1);
      if (bus.ready_o) begin
         we = s || (m_active && m_words.size() < CAP);
         check("wr_en", int'(bus.wr_en_o), int'(we));
         if (we) begin
            check("wr_addr", int'(bus.wr_addr_o), s ? 0 : m_words.size());
            check("wr_data", int'(bus.wr_data_o), int'(d));
         end
         if (s) begin
            m_words.delete();
            m_active = 1;
         end
         if (m_active) begin
            if (m_words.size() < CAP) m_words.push_back(d);
            if (e) begin
               eop_cyc = cyc;
               close_pkt();
            end
         end
      end
      @(negedge clk);
      bus.val_i = 1'b0;
      bus.sop_i = 1'b0;
      bus.eop_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bus.ready_o) && n < 3000) begin
         @(negedge clk); n++;
      end
      check("idle_timeout", int'(n < 3000), 1);
   endtask

   // ---------------- stimulus ----------------
   int len, n;
   bit s;

   initial begin
      bus.val_i  = 1'b0;
      bus.sop_i  = 1'b0;
      bus.eop_i  = 1'b0;
      bus.data_i = '0;
      srst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", int'(bus.ready_o), 0);
      check("rst_val", int'(bus.val_o), 0);
      check("rst_do_work", int'(bus.do_work_o), 0);
      check("rst_wr_en", int'(bus.wr_en_o), 0);
      check("rst_rd_req", int'(bus.rd_req_o), 0);
      check("rst_wrpntr", int'(bus.wrpntr_o), 0);
      check("rst_err", int'(bus.err_o), 0);
      srst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", int'(bus.ready_o), 1);

      // 4-word packet 3,1,4,2
      cap_q.delete(); dw_cnt = 0;
      beat(8'd3, 1, 0); beat(8'd1, 0, 0); beat(8'd4, 0, 0); beat(8'd2, 0, 1);
      wait_idle();
      check("p4_count", cap_q.size(), 4);
      for (int i = 0; i < 4; i++)
         check("p4_word", (cap_q.size() > i) ? int'(cap_q[i]) : -1, i + 1);
      check("p4_wrpntr", wp_seen, 3);
      check("p4_do_work", dw_cnt, 1);

      // single word 7
      cap_q.delete(); dw_cnt = 0;
      beat(8'd7, 1, 1);
      wait_idle();
      check("p1_do_work", dw_cnt, 0);
      check("p1_word", (cap_q.size() == 1) ? int'(cap_q[0]) : -1, 7);

      // 20-word overflow
      cap_q.delete();
      for (int i = 0; i < 20; i++) beat(word_t'($urandom), i == 0, i == 19);
      wait_idle();
      check("ovf_wrpntr", wp_seen, 15);
      check("ovf_count", cap_q.size(), 16);

      // restart by sop mid-fill
      cap_q.delete();
      beat(8'd9, 1, 0); beat(8'd8, 0, 0); beat(8'd7, 0, 0);
      beat(8'd6, 1, 0); beat(8'd5, 0, 1);
      wait_idle();
      check("rs_wrpntr", wp_seen, 1);
      check("rs_first", (cap_q.size() == 2) ? int'(cap_q[0]) : -1, 5);
      check("rs_second", (cap_q.size() == 2) ? int'(cap_q[1]) : -1, 6);

      // reset while sorting, done arrives afterwards
      cap_q.delete(); dw_cnt = 0; eng_fix = 10;
      for (int i = 0; i < 5; i++) beat(word_t'($urandom), i == 0, i == 4);
      n = 0;
      while (dw_cnt == 0 && n < 50) begin @(negedge clk); n++; end
      check("rst_sort_dw", dw_cnt, 1);
      repeat (2) @(negedge clk);
      srst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      srst = 1'b0;
      @(negedge clk);
      check("rst_sort_ready", int'(bus.ready_o), 1);
      repeat (15) @(negedge clk);
      check("rst_sort_no_out", cap_q.size(), 0);
      eng_fix = 0;
      for (int i = 0; i < 5; i++) beat(word_t'($urandom), i == 0, i == 4);
      wait_idle();
      check("rst_next_count", cap_q.size(), 5);

`ifdef SORT_CTRL_WDOG_EN
      // watchdog: engine never answers
      cap_q.delete(); err_cnt = 0; eng_hold = 1;
      beat(8'd30, 1, 0); beat(8'd20, 0, 0); beat(8'd10, 0, 1);
      exp_q.delete();
      repeat (40) @(negedge clk);
      check("wd_err_cnt", err_cnt, 1);
      check("wd_err_lat", err_cyc, dw_cyc + 15);
      check("wd_no_out", cap_q.size(), 0);
      check("wd_ready", int'(bus.ready_o), 1);
      eng_hold = 0;
      err_cnt = 0;
`endif

      // randomized packets
      for (int p = 0; p < 25; p++) begin
         len = $urandom_range(1, 20);
         if ($urandom_range(0, 3) == 0) beat(word_t'($urandom), 0, $urandom_range(0, 1) == 1);
         for (int i = 0; i < len; i++) begin
            s = (i == 0) || ($urandom_range(0, 9) == 0);
            beat(word_t'($urandom), s, i == len - 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      wait_idle();
      check("rand_drained", exp_q.size(), 0);
      check("err_count", err_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sort_ctrl.md
# sort_ctrl

Packet-level controller that sequences the bubble-sort engine. Collects one input packet into the engine's word memory, launches the sort with a single-cycle start strobe, waits for completion, then reads the sorted words back out as a framed output packet. Sits between the upstream packet source and the downstream consumer; the engine itself is a separate block driven through the ports below.

## Interface
- DWIDTH, 8: data word width.
- AWIDTH, 4: engine address width; packet capacity 2**AWIDTH words.
- WDOG_W, 12: watchdog counter width (used only with SORT_CTRL_WDOG_EN).

- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  synchronous reset, active-high.
- data_i  in  DWIDTH  input word.
- sop_i / eop_i  in  1  start / end of input packet, qualified by val_i.
- val_i  in  1  input word valid.
- ready_o  out  1  input accepted when val_i && ready_o.
- wr_en_o  out  1  engine memory write strobe.
- wr_addr_o  out  AWIDTH  engine write address.
- wr_data_o  out  DWIDTH  engine write data.
- do_work_o  out  1  one-cycle sort start strobe.
- wrpntr_o  out  AWIDTH  index of last valid word (length-1); stable from do_work_o until return to IDLE.
- done_i  in  1  engine finished sorting (one-cycle pulse).
- rd_req_o  out  1  engine read request; rd_data_i valid next cycle.
- rd_addr_o  out  AWIDTH  engine read address.
- rd_data_i  in  DWIDTH  engine read data.
- data_o  out  DWIDTH  output word.
- val_o / sop_o / eop_o  out  1  output valid / first / last word; no backpressure.
- err_o  out  1  one-cycle watchdog abort pulse (constant 0 without macro).

## Operation
- States: IDLE, FILL, START, SORT, DRAIN.
- IDLE: ready_o=1. Accepted word with sop_i: write to addr 0, cnt=1, go FILL (or START if eop_i same cycle). Accepted words without sop_i discarded.
- FILL: ready_o=1. Each accepted word written at addr cnt, cnt++. Word with sop_i restarts: written at addr 0, cnt=1. Word with eop_i: go START.
- Overflow: cnt is AWIDTH+1 bits, saturates at 2**AWIDTH; further words accepted but not written (wr_en_o=0); eop_i still closes packet.
- START: ready_o=0; wrpntr_o=cnt-1. cnt>1: do_work_o=1 one cycle, go SORT. cnt==1: no do_work_o, go DRAIN directly.
- SORT: wait for done_i, then go DRAIN. done_i outside SORT ignored.
- DRAIN: rd_req_o=1 with rd_addr_o=0..wrpntr_o on consecutive cycles; rd_data_i registered to data_o. sop_o on first word, eop_o on last (both on same word when length 1). After eop_o, return to IDLE.
- Reset: all outputs 0, state IDLE, cnt=0; in-flight packet discarded, no do_work_o or output issued.

## Timing
- Write path combinational from accepted input: wr_en_o/wr_addr_o/wr_data_o in same cycle as val_i&&ready_o.
- eop accepted in cycle N -> do_work_o high in N+1.
- done_i in cycle D -> first rd_req_o in D+1 -> first val_o in D+3 (sync read + output register).
- Output burst: val_o high for exactly length consecutive cycles.
- ready_o returns high the cycle after eop_o.
- Simultaneous sop_i and eop_i in FILL: one-word packet at addr 0, go START.

## Configuration
- SORT_CTRL_WDOG_EN defined: counter cleared on do_work_o, increments each SORT cycle; on reaching 2**WDOG_W-1 without done_i, err_o pulses one cycle, packet dropped, state IDLE, no output.
- Undefined: no counter, err_o tied 0, SORT waits indefinitely.

## Structure
- Package sort_pkg: state enum type, capacity constant derived from AWIDTH, shared with the engine.
- Sub-module sort_wdog (counter + expiry compare), instantiated only under SORT_CTRL_WDOG_EN.

## Test plan
- 4-word packet 3,1,4,2 -> writes addr 0..3, do_work_o 1 cycle after eop, wrpntr_o=3; engine model returns 1,2,3,4 -> val_o 4 cycles, sop_o on 1, eop_o on 4.
- Single word 7 with sop_i+eop_i -> no do_work_o; output one word 7 with sop_o=eop_o=1.
- 20-word packet, AWIDTH=4 -> only first 16 written, wrpntr_o=15, 16 output words.
- sop_i mid-FILL after 3 words, then 2 more words ending eop -> wrpntr_o=1, output 2 words.
- srst_i in SORT, later done_i -> no output, ready_o=1, next packet processed normally.
- With SORT_CTRL_WDOG_EN, WDOG_W=4, done_i withheld -> err_o pulses 15 cycles after do_work_o, IDLE, no val_o.
